// File: rtl/cut_test_pkg.sv
// Shared types and constants for the exhaustive CUT sweep with MISR compaction.
package cut_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  localparam int unsigned MISR_TAP   = 6;
  localparam int unsigned DEF_N_IN   = 3;
  localparam int unsigned DEF_N_OUT  = 10;
  localparam int unsigned DEF_SETTLE = 1;

endpackage

// File: rtl/cut_misr.sv
// Multiple-input signature register: shift with feedback from the top bit and one tap, XOR in d.
module cut_misr
  import cut_test_pkg::*;
#(
  parameter int unsigned N_OUT = DEF_N_OUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [N_OUT-1:0] d,
  output logic [N_OUT-1:0] sig
);

  logic [N_OUT-1:0] sig_q;
  logic [N_OUT-1:0] sig_d;

  always_comb begin
    sig_d = {sig_q[N_OUT-2:0], sig_q[N_OUT-1] ^ sig_q[MISR_TAP]} ^ d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= '0;
    end else if (clr) begin
      sig_q <= '0;
    end else if (en) begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/cut_sweep_misr.sv
// Applies every N_IN-bit vector to a combinational CUT in order and compacts its responses into a MISR.
module cut_sweep_misr
  import cut_test_pkg::*;
#(
  parameter int unsigned N_IN   = DEF_N_IN,
  parameter int unsigned N_OUT  = DEF_N_OUT,
  parameter int unsigned SETTLE = DEF_SETTLE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [N_IN-1:0]  x,
  input  logic [N_OUT-1:0] f,
  output logic             busy,
  output logic             done,
  output logic [N_OUT-1:0] signature
);

  localparam int unsigned TW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};

  state_e          state_q;
  logic [N_IN-1:0] cnt_q;
  logic [TW-1:0]   tmr_q;
  logic            busy_q;
  logic            done_q;
  logic            misr_clr_c;
  logic            misr_en_c;

  assign misr_clr_c = (state_q == ST_IDLE) && start;
  assign misr_en_c  = (state_q == ST_CAPTURE);

  // The vector counter doubles as the registered stimulus: it only moves on entry to SETTLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tmr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cnt_q   <= '0;
            tmr_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (tmr_q == TW'(SETTLE - 1)) begin
            tmr_q   <= '0;
            state_q <= ST_CAPTURE;
          end else begin
            tmr_q <= tmr_q + TW'(1);
          end
        end
        ST_CAPTURE: begin
          if (cnt_q == LAST_VEC) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q   <= cnt_q + N_IN'(1);
            state_q <= ST_SETTLE;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  cut_misr #(
    .N_OUT(N_OUT)
  ) u_misr (
    .clk(clk),
    .rst(rst),
    .clr(misr_clr_c),
    .en (misr_en_c),
    .d  (f),
    .sig(signature)
  );

  assign x    = cnt_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_cut_sweep_misr.sv
// Bench for cut_sweep_misr: two instances (SETTLE=1 and SETTLE=3) against a timeline-based reference model.
module tb_cut_sweep_misr;

  localparam int unsigned N_IN  = 3;
  localparam int unsigned N_OUT = 10;
  localparam int unsigned NVEC  = 1 << N_IN;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [N_OUT-1:0] f = '0;
  logic [N_IN-1:0]  x0, x1;
  logic             busy0, busy1, done0, done1;
  logic [N_OUT-1:0] sig0, sig1;

  int total = 0;
  int bad   = 0;
  int mode  = 1;

  always #5 clk = ~clk;

  cut_sweep_misr #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(1)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .x(x0), .f(f),
    .busy(busy0), .done(done0), .signature(sig0)
  );

  cut_sweep_misr #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(3)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .x(x1), .f(f),
    .busy(busy1), .done(done1), .signature(sig1)
  );

  // Model state: t counts edges since the accepted start; one vector period is SETTLE+1 edges.
  int               per [2] = '{2, 4};
  int               mt  [2] = '{0, 0};
  bit               mb  [2] = '{1'b0, 1'b0};
  logic [N_OUT-1:0] ms  [2] = '{'0, '0};
  logic [N_IN-1:0]  mx  [2] = '{'0, '0};

  function automatic logic [N_OUT-1:0] misr_step(input logic [N_OUT-1:0] s, input logic [N_OUT-1:0] d);
    logic [N_OUT-1:0] n;
    n[0] = s[N_OUT-1] ^ s[6] ^ d[0];
    for (int i = 1; i < N_OUT; i++) n[i] = s[i-1] ^ d[i];
    return n;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      int len;
      len = int'(NVEC) * per[k];
      if (rst) begin
        mb[k] = 1'b0; mt[k] = 0; ms[k] = '0; mx[k] = '0;
      end else if (!mb[k]) begin
        if (start) begin
          mb[k] = 1'b1; mt[k] = 0; ms[k] = '0; mx[k] = '0;
        end
      end else if (mt[k] == len) begin
        mb[k] = 1'b0;
      end else begin
        mt[k]++;
        if (mt[k] % per[k] == 0) ms[k] = misr_step(ms[k], f);
        if (mt[k] < len) mx[k] = N_IN'(mt[k] / per[k]);
      end
    end
  endtask

  // Model update on every clock edge (and immediately on reset), compare just after.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      model_step();
      #1;
      chk("x0", int'(x0), int'(mx[0]));
      chk("busy0", int'(busy0), int'(mb[0]));
      chk("done0", int'(done0), int'(mb[0] && mt[0] == int'(NVEC) * per[0]));
      chk("sig0", int'(sig0), int'(ms[0]));
      chk("x1", int'(x1), int'(mx[1]));
      chk("busy1", int'(busy1), int'(mb[1]));
      chk("done1", int'(done1), int'(mb[1] && mt[1] == int'(NVEC) * per[1]));
      chk("sig1", int'(sig1), int'(ms[1]));
    end
  end

  // CUT response generator, keyed on dut0's stimulus.
  initial begin
    forever begin
      @(negedge clk);
      case (mode)
        0:       f = N_OUT'($urandom);
        2:       f = (x0 == 3'd7) ? 10'h3FF : 10'h000;
        3:       f = (x0 == 3'd6) ? 10'h001 : 10'h000;
        default: f = '0;
      endcase
    end
  end

  task automatic run_sweep(output int n0, output int n1, output int tr0);
    logic [N_IN-1:0] prev;
    n0 = -1; n1 = -1; tr0 = 0; prev = '0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start = 1'b0;
        prev  = x0;
      end else if (x0 != prev) begin
        tr0++;
        prev = x0;
      end
      if (done0 && n0 < 0) n0 = i;
      if (done1 && n1 < 0) n1 = i;
      if (n0 > 0 && n1 > 0) break;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 80; i++) begin
      if (!busy0 && !busy1) break;
      @(negedge clk);
    end
    chk("idle_timeout", int'(busy0 | busy1), 0);
  endtask

  initial begin
    int n0, n1, tr0, seen, rep;

    repeat (3) @(negedge clk);
    chk("rst_x", int'(x0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_sig", int'(sig0), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // All-zero responses: latency and stimulus order for both settle depths.
    mode = 1;
    run_sweep(n0, n1, tr0);
    chk("lat_settle1", n0, 17);
    chk("lat_settle3", n1, 33);
    chk("x_steps", tr0, 7);
    chk("sig_zero0", int'(sig0), 'h000);
    chk("sig_zero1", int'(sig1), 'h000);
    chk("x_final", int'(x0), 7);

    mode = 2;
    run_sweep(n0, n1, tr0);
    chk("lat_ff", n0, 17);
    chk("sig_ff_at7", int'(sig0), 'h3FF);

    mode = 3;
    run_sweep(n0, n1, tr0);
    chk("sig_one_at6", int'(sig0), 'h002);

    // Abort mid-sweep with reset while x=4.
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (x0 == 3'd4) break;
      @(negedge clk);
    end
    chk("reach_x4", int'(x0), 4);
    rst = 1'b1;
    #1;
    chk("abort_x", int'(x0), 0);
    chk("abort_sig", int'(sig0), 0);
    chk("abort_busy", int'(busy0), 0);
    chk("abort_done", int'(done0), 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done0 || done1) seen++;
    end
    chk("no_done_after_abort", seen, 0);
    mode = 1;
    run_sweep(n0, n1, tr0);
    chk("lat_after_abort", n0, 17);
    chk("x_steps_after_abort", tr0, 7);

    // Start re-pulsed at x=3 must not disturb the running sweep.
    mode = 2;
    n0 = -1; rep = 0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      else if (start) start = 1'b0;
      else if (x0 == 3'd3 && rep == 0) begin
        start = 1'b1;
        rep = 1;
      end
      if (done0) begin
        n0 = i;
        break;
      end
    end
    chk("repulse_seen", rep, 1);
    chk("lat_repulse", n0, 17);
    chk("sig_repulse", int'(sig0), 'h3FF);
    wait_idle();

    // Start held high across DONE relaunches immediately; then random traffic.
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    repeat (70) @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (600) begin
      @(negedge clk);
      start = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 149) == 0);
    end
    rst = 1'b0;
    start = 1'b0;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cut_sweep_misr.md
CUT_SWEEP_MISR -- requirements
Module: cut_sweep_misr

Interface
REQ-001 SHALL have parameter N_IN, default 3: width of the stimulus vector driven into the combinational circuit under test (CUT).
REQ-002 SHALL have parameter N_OUT, default 10: width of the CUT response and of the signature (minimum 8).
REQ-003 SHALL have parameter SETTLE, default 1: number of wait cycles between applying a vector and capturing the response (minimum 1).
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port start, input, 1 bit: sweep request, sampled only in IDLE.
REQ-007 SHALL have port x, output, N_IN bits: stimulus vector to the CUT inputs x0..x(N_IN-1); bit i drives xi.
REQ-008 SHALL have port f, input, N_OUT bits: CUT response f1..fN_OUT; bit i-1 carries fi.
REQ-009 SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-010 SHALL have port done, output, 1 bit: single-cycle pulse marking the end of a sweep.
REQ-011 SHALL have port signature, output, N_OUT bits: MISR contents, stable from done until the next accepted start.

Function
REQ-012 SHALL implement FSM states IDLE, SETTLE, CAPTURE and DONE.
REQ-013 IDLE, start=1: SHALL clear signature and the vector counter to 0, drive x=0, and go to SETTLE.
REQ-014 IDLE, start=0: SHALL hold x and signature.
REQ-015 SETTLE SHALL last exactly SETTLE cycles, then go to CAPTURE.
REQ-016 CAPTURE SHALL last one cycle, sample f, and update the signature as follows:
- next[0] = sig[N_OUT-1] ^ sig[6] ^ f[0];
- next[i] = sig[i-1] ^ f[i], for i >= 1.
REQ-017 CAPTURE with counter < 2^N_IN-1: SHALL increment the counter, drive x = new counter value, and go to SETTLE.
REQ-018 CAPTURE with counter = 2^N_IN-1: SHALL go to DONE and SHALL NOT wrap the counter.
REQ-019 DONE SHALL assert done for exactly one cycle and then go to IDLE.
REQ-020 busy SHALL be high in SETTLE, CAPTURE and DONE, and low in IDLE.
REQ-021 x SHALL be registered; it changes only on the edge that enters SETTLE.
REQ-022 Timing: if start is sampled at edge k, done SHALL be high in the cycle after edge k+2^N_IN*(SETTLE+1).
- Defaults: 16 cycles, done in the cycle after edge k+16.
REQ-023 start asserted while busy SHALL be ignored (no restart, no queueing).
REQ-024 start held high across DONE SHALL launch a new sweep on the first IDLE cycle.
REQ-025 f SHALL be used only in CAPTURE; its value in other states SHALL have no effect.

Reset
REQ-026 rst=1 SHALL immediately force the following, regardless of the clock: state IDLE, x=0, counter=0, signature=0, busy=0, done=0.
REQ-027 rst asserted mid-sweep SHALL abort the sweep; no done pulse SHALL be produced for it.
REQ-028 After rst deasserts, the block SHALL wait in IDLE for start.

Structure
REQ-029 A shared package cut_test_pkg SHALL hold:
- the FSM state enum;
- the MISR feedback tap index constant (6);
- default parameter constants.
REQ-030 The MISR SHALL be a separate sub-module cut_misr with:
- parameter N_OUT;
- inputs clk, rst, clr, en, d;
- output sig.
REQ-031 The sequencer (FSM, counter, settle timer) SHALL reside in cut_sweep_misr.

Verification
REQ-032 f tied to 0, pulse start -> done in the cycle after edge start+16, signature=10'h000, x visits 0..7 in order.
REQ-033 f=10'h3FF only while x=7 (else 0) -> signature=10'h3FF.
REQ-034 f=10'h001 only while x=6 (else 0) -> signature=10'h002.
REQ-035 rst pulsed while x=4 -> x, signature, busy and done all 0 at once, no done pulse, next start gives a full 8-vector sweep.
REQ-036 start re-pulsed while x=3 -> ignored, sweep completes at the original cycle with an unchanged signature.
REQ-037 SETTLE=3 with f=0 -> done in the cycle after edge start+32, each x held for 4 cycles.
